emulador_ultrassonico: RTL



---
 rtl/emulador_ultrassonico.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/emulador_ultrassonico.sv
// emulador_ultrassonico
// Emulates an HC-SR04 ultrasonic sensor and the four active-low floor-limit
// sensors of the cargo shaft. It answers a measurement request on `trigger`
// with an `echo` pulse whose width encodes the cabin distance.
//
// Ports:
//   clock            in   system clock
//   reset            in   asynchronous, active-high
//   trigger          in   measurement request, synchronous to clock
//   posicao_cm       in   [8:0] current emulated cabin distance in cm
//   echo             out  echo pulse, registered
//   sensores         out  [3:0] floor sensors, active-low, bit k = floor k
//   ocupado          out  high during ESPERA, ECO and RECUPERA
//   pulso_curto      out  one-cycle flag: trigger shorter than MIN_TRIGGER
//   trigger_ignorado out  one-cycle flag: trigger rising edge while ocupado
module emulador_ultrassonico #(
  parameter int CICLOS_POR_CM   = 2941,
  parameter int MIN_TRIGGER     = 500,
  parameter int ATRASO_ECHO     = 25000,
  parameter int RECUPERACAO     = 50000,
  parameter int MAX_CM          = 400,
  parameter int ECO_TIMEOUT     = 1900000,
  parameter int BASE_CM         = 5,
  parameter int ALTURA_ANDAR_CM = 20,
  parameter int TOLERANCIA_CM   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] posicao_cm,
  output logic       echo,
  output logic [3:0] sensores,
  output logic       ocupado,
  output logic       pulso_curto,
  output logic       trigger_ignorado
);

  // One shared counter serves ESPERA, RECUPERA and the out-of-range echo,
  // so it is sized for the largest of the three intervals.
  localparam int CONT_MAX_A = (ATRASO_ECHO > RECUPERACAO) ? ATRASO_ECHO : RECUPERACAO;
  localparam int CONT_MAX   = (CONT_MAX_A > ECO_TIMEOUT) ? CONT_MAX_A : ECO_TIMEOUT;
  localparam int CONT_W     = $clog2(CONT_MAX + 1);
  localparam int ALTO_W     = $clog2(MIN_TRIGGER + 1);
  localparam int SUB_W      = $clog2(CICLOS_POR_CM + 1);

  localparam logic [CONT_W-1:0] CONT_ZERO   = '0;
  localparam logic [CONT_W-1:0] CONT_UM     = CONT_W'(1);
  localparam logic [CONT_W-1:0] ATRASO_FIM  = CONT_W'(ATRASO_ECHO - 1);
  localparam logic [CONT_W-1:0] RECUP_FIM   = CONT_W'(RECUPERACAO - 1);
  localparam logic [CONT_W-1:0] TIMEOUT_FIM = CONT_W'(ECO_TIMEOUT - 1);
  localparam logic [ALTO_W-1:0] ALTO_ZERO   = '0;
  localparam logic [ALTO_W-1:0] ALTO_UM     = ALTO_W'(1);
  localparam logic [ALTO_W-1:0] ALTO_MIN    = ALTO_W'(MIN_TRIGGER);
  localparam logic [SUB_W-1:0]  SUB_ZERO    = '0;
  localparam logic [SUB_W-1:0]  SUB_UM      = SUB_W'(1);
  localparam logic [SUB_W-1:0]  SUB_FIM     = SUB_W'(CICLOS_POR_CM - 1);
  localparam logic [8:0]        MAX_CM_L    = 9'(MAX_CM);
  localparam logic signed [10:0] TOL_POS    = 11'(TOLERANCIA_CM);
  localparam logic signed [10:0] TOL_NEG    = 11'(-TOLERANCIA_CM);

  typedef enum logic [2:0] {OCIOSO, TRIGGER, ESPERA, ECO, RECUPERA} estado_t;

  estado_t           estado, estado_prox;
  logic [ALTO_W-1:0] cont_alto, cont_alto_prox;
  logic [CONT_W-1:0] cont, cont_prox;
  logic [8:0]        cont_cm, cont_cm_prox;
  logic [SUB_W-1:0]  cont_sub, cont_sub_prox;
  logic [8:0]        pos_lat, pos_lat_prox;
  logic              pulso_curto_prox;
  logic              trigger_ant;
  logic              fora_faixa;
  logic [3:0]        sensores_prox;
  logic signed [10:0] pos_ext;
  logic signed [10:0] centro;
  logic signed [10:0] diff;

  assign fora_faixa = (pos_lat > MAX_CM_L);
  assign ocupado    = (estado == ESPERA) || (estado == ECO) || (estado == RECUPERA);

  // State and counter registers; echo and the flags are registered off the
  // next-state values so they line up exactly with the FSM transitions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado           <= OCIOSO;
      cont_alto        <= ALTO_ZERO;
      cont             <= CONT_ZERO;
      cont_cm          <= 9'd0;
      cont_sub         <= SUB_ZERO;
      pos_lat          <= 9'd0;
      trigger_ant      <= 1'b0;
      echo             <= 1'b0;
      pulso_curto      <= 1'b0;
      trigger_ignorado <= 1'b0;
      sensores         <= 4'b1111;
    end else begin
      estado           <= estado_prox;
      cont_alto        <= cont_alto_prox;
      cont             <= cont_prox;
      cont_cm          <= cont_cm_prox;
      cont_sub         <= cont_sub_prox;
      pos_lat          <= pos_lat_prox;
      trigger_ant      <= trigger;
      echo             <= (estado_prox == ECO);
      pulso_curto      <= pulso_curto_prox;
      trigger_ignorado <= trigger && !trigger_ant && ocupado;
      sensores         <= sensores_prox;
    end
  end

  // Next-state logic. The echo width is produced as cm x CICLOS_POR_CM by
  // decrementing a cm counter each time the sub-cycle counter wraps, which
  // avoids a multiplier; out-of-range distances use the shared counter.
  always_comb begin
    estado_prox      = estado;
    cont_alto_prox   = cont_alto;
    cont_prox        = cont;
    cont_cm_prox     = cont_cm;
    cont_sub_prox    = cont_sub;
    pos_lat_prox     = pos_lat;
    pulso_curto_prox = 1'b0;
    case (estado)
      OCIOSO: begin
        if (trigger) begin
          estado_prox    = TRIGGER;
          cont_alto_prox = ALTO_UM;
        end
      end
      TRIGGER: begin
        if (trigger) begin
          if (cont_alto < ALTO_MIN) cont_alto_prox = cont_alto + ALTO_UM;
        end else if (cont_alto >= ALTO_MIN) begin
          estado_prox    = ESPERA;
          pos_lat_prox   = posicao_cm;
          cont_prox      = CONT_ZERO;
          cont_alto_prox = ALTO_ZERO;
        end else begin
          estado_prox      = OCIOSO;
          pulso_curto_prox = 1'b1;
          cont_alto_prox   = ALTO_ZERO;
        end
      end
      ESPERA: begin
        if (cont == ATRASO_FIM) begin
          estado_prox   = ECO;
          cont_prox     = CONT_ZERO;
          cont_sub_prox = SUB_ZERO;
          cont_cm_prox  = (pos_lat == 9'd0) ? 9'd1 : pos_lat;
        end else begin
          cont_prox = cont + CONT_UM;
        end
      end
      ECO: begin
        if (fora_faixa) begin
          if (cont == TIMEOUT_FIM) begin
            estado_prox = RECUPERA;
            cont_prox   = CONT_ZERO;
          end else begin
            cont_prox = cont + CONT_UM;
          end
        end else if (cont_sub == SUB_FIM) begin
          cont_sub_prox = SUB_ZERO;
          if (cont_cm == 9'd1) begin
            estado_prox = RECUPERA;
            cont_prox   = CONT_ZERO;
          end else begin
            cont_cm_prox = cont_cm - 9'd1;
          end
        end else begin
          cont_sub_prox = cont_sub + SUB_UM;
        end
      end
      RECUPERA: begin
        if (cont == RECUP_FIM) begin
          estado_prox = OCIOSO;
          cont_prox   = CONT_ZERO;
        end else begin
          cont_prox = cont + CONT_UM;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // Floor sensors follow the live position; signed 11-bit math keeps the
  // distance to a floor centre from wrapping near zero.
  always_comb begin
    sensores_prox = 4'b1111;
    pos_ext       = $signed({2'b00, posicao_cm});
    centro        = '0;
    diff          = '0;
    for (int k = 0; k < 4; k++) begin
      centro = 11'(BASE_CM + k * ALTURA_ANDAR_CM);
      diff   = pos_ext - centro;
      if (diff >= TOL_NEG && diff <= TOL_POS) sensores_prox[k] = 1'b0;
    end
  end

endmodule
